// File: rtl/tt_um_jleugeri_ttt_scheduler.sv
// Sweep scheduler for a time-multiplexed token core: init, programming pass-through,
// per-tick update/evaluate/capture over all processors, and a start/stop event FIFO.
module tt_um_jleugeri_ttt_scheduler #(
  parameter int NUM_PROCESSORS  = 10,
  parameter int NEW_TOKENS_BITS = 4,
  parameter int PROG_WIDTH      = 8,
  parameter int FIFO_DEPTH      = 4,
  localparam int IDW            = $clog2(NUM_PROCESSORS)
) (
  input  logic                              clock_fast,
  input  logic                              reset,
  input  logic                              tick,
  input  logic                              inj_valid,
  input  logic [IDW-1:0]                    inj_id,
  input  logic signed [NEW_TOKENS_BITS-1:0] inj_good,
  input  logic signed [NEW_TOKENS_BITS-1:0] inj_bad,
  input  logic                              prog_valid,
  output logic                              prog_ready,
  input  logic [1:0]                        prog_sel,
  input  logic [IDW-1:0]                    prog_id,
  input  logic [PROG_WIDTH-1:0]             prog_data,
  output logic                              core_reset,
  output logic                              core_clock_slow,
  output logic [IDW-1:0]                    core_processor_id,
  output logic [2:0]                        core_instruction,
  output logic signed [NEW_TOKENS_BITS-1:0] core_new_good,
  output logic signed [NEW_TOKENS_BITS-1:0] core_new_bad,
  output logic [PROG_WIDTH-1:0]             core_prog_data,
  input  logic [1:0]                        core_token_startstop,
  output logic                              evt_valid,
  input  logic                              evt_ready,
  output logic [IDW-1:0]                    evt_id,
  output logic                              evt_start,
  output logic                              busy,
  output logic                              tick_overrun
);
  localparam int NTB = NEW_TOKENS_BITS;
  localparam int PW  = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_UPD, S_EVAL, S_CAPT} state_t;

  state_t           state_reg;
  logic [IDW-1:0]   p_reg;
  logic             tick_pending_reg;
  logic             tick_overrun_reg;

  logic [IDW:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]      count_reg;

  logic signed [NTB-1:0] pend_good [NUM_PROCESSORS];
  logic signed [NTB-1:0] pend_bad  [NUM_PROCESSORS];

  logic last_p, evt_found, fifo_full, push, pop, capt_done, prog_xfer;

  function automatic logic signed [NTB-1:0] sat_add(input logic signed [NTB-1:0] a,
                                                     input logic signed [NTB-1:0] b);
    logic [NTB:0] s;
    s = {a[NTB-1], a} + {b[NTB-1], b};
    if (s[NTB] != s[NTB-1])
      return s[NTB] ? {1'b1, {(NTB-1){1'b0}}} : {1'b0, {(NTB-1){1'b1}}};
    return s[NTB-1:0];
  endfunction

  assign last_p     = (p_reg == IDW'(NUM_PROCESSORS - 1));
  assign evt_found  = core_token_startstop[1] ^ core_token_startstop[0];
  assign fifo_full  = (count_reg == (PW+1)'(FIFO_DEPTH));
  // A capture needing a push waits in place while the FIFO is full.
  assign push       = (state_reg == S_CAPT) && evt_found && !fifo_full;
  assign capt_done  = (state_reg == S_CAPT) && !(evt_found && fifo_full);
  assign evt_valid  = (count_reg != '0);
  assign pop        = evt_valid && evt_ready;
  assign prog_ready = (state_reg == S_IDLE) && !tick_pending_reg && !tick;
  assign prog_xfer  = prog_valid && prog_ready && (prog_sel != 2'b00);

  always_ff @(posedge clock_fast) begin
    if (reset) begin
      state_reg        <= S_INIT;
      p_reg            <= '0;
      tick_pending_reg <= 1'b0;
      tick_overrun_reg <= 1'b0;
    end else begin
      if (tick && tick_pending_reg) tick_overrun_reg <= 1'b1;
      if (tick && state_reg != S_IDLE) tick_pending_reg <= 1'b1;
      case (state_reg)
        S_INIT: begin
          if (last_p) begin
            state_reg <= S_IDLE;
            p_reg     <= '0;
          end else begin
            p_reg <= p_reg + 1'b1;
          end
        end
        S_IDLE: begin
          if (tick_pending_reg || tick) begin
            tick_pending_reg <= 1'b0;
            p_reg            <= '0;
            state_reg        <= S_UPD;
          end
        end
        S_UPD:  state_reg <= S_EVAL;
        S_EVAL: state_reg <= S_CAPT;
        S_CAPT: begin
          if (capt_done) begin
            if (last_p) begin
              state_reg <= S_IDLE;
            end else begin
              p_reg     <= p_reg + 1'b1;
              state_reg <= S_UPD;
            end
          end
        end
        default: state_reg <= S_INIT;
      endcase
    end
  end

  always_ff @(posedge clock_fast) begin
    if (push) fifo_mem[wr_ptr_reg] <= {p_reg, core_token_startstop[1]};
  end

  always_ff @(posedge clock_fast) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign {evt_id, evt_start} = fifo_mem[rd_ptr_reg];

  // An injection landing on the entry being consumed starts it fresh for the next sweep.
  generate
    for (genvar gi = 0; gi < NUM_PROCESSORS; gi++) begin : g_pend
      logic                  hit, clr;
      logic signed [NTB-1:0] good_reg, bad_reg, base_good, base_bad;

      assign hit       = inj_valid && (inj_id == IDW'(gi));
      assign clr       = (state_reg == S_UPD) && (p_reg == IDW'(gi));
      assign base_good = clr ? '0 : good_reg;
      assign base_bad  = clr ? '0 : bad_reg;

      always_ff @(posedge clock_fast) begin
        if (reset) begin
          good_reg <= '0;
          bad_reg  <= '0;
        end else if (hit) begin
          good_reg <= sat_add(base_good, inj_good);
          bad_reg  <= sat_add(base_bad, inj_bad);
        end else if (clr) begin
          good_reg <= '0;
          bad_reg  <= '0;
        end
      end

      assign pend_good[gi] = good_reg;
      assign pend_bad[gi]  = bad_reg;
    end
  endgenerate

  always_comb begin
    core_instruction  = 3'b000;
    core_processor_id = p_reg;
    core_prog_data    = '0;
    core_new_good     = '0;
    core_new_bad      = '0;
    case (state_reg)
      S_IDLE: begin
        if (prog_xfer) begin
          core_instruction  = {1'b0, prog_sel};
          core_processor_id = prog_id;
          core_prog_data    = prog_data;
        end
      end
      S_UPD: begin
        core_instruction = 3'b100;
        core_new_good    = pend_good[p_reg];
        core_new_bad     = pend_bad[p_reg];
      end
      S_EVAL:  core_instruction = 3'b101;
      default: core_instruction = 3'b000;
    endcase
  end

  assign core_reset      = (state_reg == S_INIT);
  assign core_clock_slow = (state_reg == S_UPD) || (state_reg == S_EVAL) || (state_reg == S_CAPT);
  assign busy            = (state_reg != S_IDLE);
  assign tick_overrun    = tick_overrun_reg;

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_scheduler.sv
// Randomized bench for the sweep scheduler against a behavioural model of sweeps,
// token accumulation and the event stream.
module tb_tt_um_jleugeri_ttt_scheduler;
  localparam int NP = 10, NTB = 4, PWD = 8, IDW = 4;

  logic clock_fast = 1'b0;
  logic reset = 1'b1, tick = 1'b0;
  logic inj_valid = 1'b0;
  logic [IDW-1:0] inj_id = '0;
  logic signed [NTB-1:0] inj_good = '0, inj_bad = '0;
  logic prog_valid = 1'b0, prog_ready;
  logic [1:0] prog_sel = '0;
  logic [IDW-1:0] prog_id = '0;
  logic [PWD-1:0] prog_data = '0;
  logic core_reset, core_clock_slow;
  logic [IDW-1:0] core_processor_id;
  logic [2:0] core_instruction;
  logic signed [NTB-1:0] core_new_good, core_new_bad;
  logic [PWD-1:0] core_prog_data;
  logic [1:0] core_ss = 2'b00;
  logic evt_valid, evt_ready = 1'b1;
  logic [IDW-1:0] evt_id;
  logic evt_start, busy, tick_overrun;

  tt_um_jleugeri_ttt_scheduler dut (
    .clock_fast(clock_fast), .reset(reset), .tick(tick),
    .inj_valid(inj_valid), .inj_id(inj_id), .inj_good(inj_good), .inj_bad(inj_bad),
    .prog_valid(prog_valid), .prog_ready(prog_ready), .prog_sel(prog_sel),
    .prog_id(prog_id), .prog_data(prog_data),
    .core_reset(core_reset), .core_clock_slow(core_clock_slow),
    .core_processor_id(core_processor_id), .core_instruction(core_instruction),
    .core_new_good(core_new_good), .core_new_bad(core_new_bad),
    .core_prog_data(core_prog_data), .core_token_startstop(core_ss),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id), .evt_start(evt_start),
    .busy(busy), .tick_overrun(tick_overrun)
  );

  always #5 clock_fast = ~clock_fast;

  int errors = 0, checks = 0;
  int mp_good [NP];
  int mp_bad  [NP];
  logic [1:0] ss_table [16];
  logic [IDW:0] got [$];
  logic [IDW:0] exp_ev [$];
  int exp_p = 0;

  // Core stand-in: start/stop answer registered after an evaluate instruction.
  always @(posedge clock_fast)
    if (core_instruction == 3'b101) core_ss <= ss_table[core_processor_id];

  task automatic chk(input string tag, input int got_v, input int exp_v);
    checks++;
    if (got_v != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 7) return 7;
    if (v < -8) return -8;
    return v;
  endfunction

  task automatic observe();
    if (reset) begin
      for (int i = 0; i < NP; i++) begin mp_good[i] = 0; mp_bad[i] = 0; end
    end else begin
      if (core_instruction == 3'b100) begin
        chk("upd_id", core_processor_id, exp_p);
        if (exp_p < NP) begin
          chk("upd_good", core_new_good, mp_good[exp_p]);
          chk("upd_bad", core_new_bad, mp_bad[exp_p]);
          mp_good[exp_p] = 0;
          mp_bad[exp_p]  = 0;
        end
        exp_p++;
      end
      if (inj_valid && inj_id < NP) begin
        mp_good[inj_id] = sat(mp_good[inj_id] + inj_good);
        mp_bad[inj_id]  = sat(mp_bad[inj_id] + inj_bad);
      end
      if (evt_valid && evt_ready) got.push_back({evt_id, evt_start});
    end
  endtask

  task automatic step();
    #1;
    observe();
    @(negedge clock_fast);
  endtask

  task automatic rand_inj();
    inj_valid = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) == 0 && exp_p < NP) inj_id = IDW'(exp_p);
    else inj_id = IDW'($urandom_range(0, 15));
    inj_good = NTB'($urandom_range(0, 15));
    inj_bad  = NTB'($urandom_range(0, 15));
  endtask

  task automatic check_init();
    reset = 1'b0;
    for (int i = 0; i < NP; i++) begin
      #1;
      chk("init_rst", core_reset, 1);
      chk("init_id", core_processor_id, i);
      chk("init_busy", busy, 1);
      chk("init_instr", core_instruction, 0);
      chk("init_slow", core_clock_slow, 0);
      step();
    end
    #1;
    chk("idle_rst", core_reset, 0);
    chk("idle_ready", prog_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_evt", evt_valid, 0);
  endtask

  task automatic prog_test(input int n);
    bit xfer;
    for (int k = 0; k < n; k++) begin
      if (k == 0) begin
        prog_valid = 1'b1; prog_sel = 2'd2; prog_id = 4'd3; prog_data = 8'd5;
      end else begin
        prog_valid = 1'($urandom_range(0, 1));
        prog_sel   = 2'($urandom_range(0, 3));
        prog_id    = IDW'($urandom_range(0, 15));
        prog_data  = PWD'($urandom);
      end
      #1;
      xfer = prog_valid && (prog_sel != 2'b00);
      chk("prog_ready", prog_ready, 1);
      chk("prog_instr", core_instruction, xfer ? int'(prog_sel) : 0);
      if (xfer) begin
        chk("prog_id", core_processor_id, prog_id);
        chk("prog_data", core_prog_data, prog_data);
      end
      step();
    end
    prog_valid = 1'b0;
  endtask

  // mode 0: evt_ready held high; 1: random; 2: low until the sweep has stalled.
  task automatic run_sweep(input bit do_tick, input int mode, input bit inj_on, input bit mid_ticks);
    int n, cyc_cnt, stall_expect;
    logic [IDW:0] e;
    exp_ev.delete(); got.delete(); exp_p = 0;
    for (int i = 0; i < NP; i++) begin
      if (ss_table[i] == 2'b10) exp_ev.push_back({IDW'(i), 1'b1});
      else if (ss_table[i] == 2'b01) exp_ev.push_back({IDW'(i), 1'b0});
    end
    stall_expect = 0;
    if (exp_ev.size() > 4) begin e = exp_ev[4]; stall_expect = int'(e[IDW:1]) + 1; end
    evt_ready = (mode != 2);
    if (do_tick) begin
      tick = 1'b1;
      #1;
      chk("tick_ready", prog_ready, 0);
      chk("tick_instr", core_instruction, 0);
      step();
      tick = 1'b0;
      prog_valid = 1'b0;
    end
    n = 0;
    while (!busy && n < 5) begin
      if (inj_on) rand_inj();
      step();
      n++;
    end
    if (!busy) chk("sweep_start_timeout", busy, 1);
    cyc_cnt = 0;
    while (busy && cyc_cnt < 400) begin
      if (inj_on) rand_inj(); else inj_valid = 1'b0;
      if (mode == 1) evt_ready = 1'($urandom_range(0, 1));
      tick = mid_ticks && (cyc_cnt == 4 || cyc_cnt == 11);
      #1;
      chk("sweep_slow", core_clock_slow, 1);
      if (mode == 2 && cyc_cnt == 60) begin
        chk("stall_busy", busy, 1);
        chk("stall_evt", evt_valid, 1);
        chk("stall_instr", core_instruction, 0);
        chk("stall_got", got.size(), 0);
        chk("stall_p", exp_p, stall_expect);
        evt_ready = 1'b1;
      end
      step();
      cyc_cnt++;
    end
    tick = 1'b0; inj_valid = 1'b0;
    if (cyc_cnt >= 400) chk("sweep_timeout", cyc_cnt, 0);
    if (mode == 0) chk("sweep_len", cyc_cnt, 3 * NP);
    chk("upd_count", exp_p, NP);
    evt_ready = 1'b1;
    n = 0;
    while (evt_valid && n < 10) begin step(); n++; end
    chk("evt_count", got.size(), exp_ev.size());
    foreach (exp_ev[i]) if (i < got.size()) chk("evt", got[i], exp_ev[i]);
    $display("sweep mode=%0d cycles=%0d events=%0d", mode, cyc_cnt, got.size());
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) ss_table[i] = 2'b00;
    for (int i = 0; i < NP; i++) begin mp_good[i] = 0; mp_bad[i] = 0; end
    repeat (3) @(negedge clock_fast);
    check_init();
    chk("ovr_reset", tick_overrun, 0);
    prog_test(12);

    // Saturation on one entry, then an empty follow-up sweep.
    for (int k = 0; k < 2; k++) begin
      inj_valid = 1'b1; inj_id = 4'd2; inj_good = 4'sd5; inj_bad = 4'sd0;
      step();
    end
    inj_valid = 1'b0;
    run_sweep(1, 0, 0, 0);
    run_sweep(1, 0, 0, 0);

    // Two events in id order, full-rate sweep.
    ss_table[1] = 2'b10; ss_table[4] = 2'b01;
    run_sweep(1, 0, 0, 0);

    // Tick arriving together with a programming request.
    prog_valid = 1'b1; prog_sel = 2'd1; prog_id = 4'd6; prog_data = 8'h3c;
    run_sweep(1, 0, 0, 0);

    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < NP; i++) ss_table[i] = 2'($urandom_range(0, 3));
      for (int k = 0; k < 5; k++) begin rand_inj(); step(); end
      inj_valid = 1'b0;
      run_sweep(1, s % 2, 1, 0);
    end

    // Backpressure: five starts against a four-entry FIFO.
    for (int i = 0; i < NP; i++) ss_table[i] = 2'b00;
    ss_table[0] = 2'b10; ss_table[2] = 2'b10; ss_table[3] = 2'b10;
    ss_table[6] = 2'b10; ss_table[8] = 2'b10; ss_table[9] = 2'b11;
    run_sweep(1, 2, 0, 0);

    // Two ticks during a sweep: overrun flag and exactly one extra sweep.
    for (int i = 0; i < NP; i++) ss_table[i] = 2'b00;
    run_sweep(1, 0, 0, 1);
    chk("overrun", tick_overrun, 1);
    run_sweep(0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin #1; chk("no_extra_sweep", busy, 0); step(); end
    chk("overrun_sticky", tick_overrun, 1);

    // Reset mid-sweep with a queued event, tick and injection during reset.
    ss_table[0] = 2'b10;
    exp_p = 0;
    evt_ready = 1'b0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    for (int k = 0; k < 14; k++) step();
    #1;
    chk("pre_reset_evt", evt_valid, 1);
    reset = 1'b1; tick = 1'b1;
    inj_valid = 1'b1; inj_id = 4'd0; inj_good = 4'sd3; inj_bad = -4'sd2;
    step(); step();
    #1;
    chk("rst_evt", evt_valid, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_instr", core_instruction, 0);
    chk("rst_slow", core_clock_slow, 0);
    chk("rst_ready", prog_ready, 0);
    chk("rst_overrun", tick_overrun, 0);
    tick = 1'b0; inj_valid = 1'b0; evt_ready = 1'b1;
    check_init();
    for (int k = 0; k < 3; k++) begin #1; chk("post_reset_idle", busy, 0); step(); end
    ss_table[0] = 2'b00;
    run_sweep(1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tt_um_jleugeri_ttt_scheduler.md
TT_UM_JLEUGERI_TTT_SCHEDULER -- requirements
Module: tt_um_jleugeri_ttt_scheduler

Interface
REQ-001 Parameters: NUM_PROCESSORS 10 (processor count); NEW_TOKENS_BITS 4 (signed token-delta width); PROG_WIDTH 8 (program data width); FIFO_DEPTH 4 (event FIFO entries, power of 2).
REQ-002 Ports; IDW = $clog2(NUM_PROCESSORS). One clock; reset is synchronous and active-high.
REQ-003 clock_fast  in  1  sole clock, rising edge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 tick  in  1  one-cycle pulse requesting one slow-time sweep.
REQ-006 inj_valid / inj_id / inj_good / inj_bad  in  1 / IDW / NEW_TOKENS_BITS signed / NEW_TOKENS_BITS signed  token injection for processor inj_id.
REQ-007 prog_valid / prog_ready  in / out  1 / 1  programming handshake.
REQ-008 prog_sel / prog_id / prog_data  in  2 / IDW / PROG_WIDTH  target (1 duration, 2 good threshold, 3 bad threshold; 0 ignored), processor, value.
REQ-009 core_reset / core_clock_slow  out  1 / 1  drive core reset and clock_slow.
REQ-010 core_processor_id / core_instruction  out  IDW / 3  drive core processor_id and instruction.
REQ-011 core_new_good / core_new_bad  out  NEW_TOKENS_BITS signed each  drive core token inputs.
REQ-012 core_prog_data  out  PROG_WIDTH  drives core prog_data.
REQ-013 core_token_startstop  in  2  core output, registered, valid the cycle after instruction 101.
REQ-014 evt_valid / evt_ready  out / in  1 / 1  event FIFO head handshake.
REQ-015 evt_id / evt_start  out  IDW / 1  event processor; 1 = start (10), 0 = stop (01).
REQ-016 busy / tick_overrun  out  1 / 1  sweep or init in progress; sticky missed-tick flag.

Function
REQ-017 States: INIT, IDLE, UPD, EVAL, CAPT; current processor index p.
REQ-018 INIT: core_reset=1, core_instruction=000, core_processor_id=p, p counts 0..NUM_PROCESSORS-1, one cycle each, then IDLE.
REQ-019 IDLE: core_instruction=000; tick_pending has priority over programming; if set, clear it, p=0, go UPD.
REQ-020 prog_ready=1 only in IDLE with tick_pending=0 and no tick this cycle; a transfer (prog_valid&prog_ready, prog_sel!=0) drives core_instruction={1'b0,prog_sel}, core_processor_id=prog_id, core_prog_data=prog_data that same cycle (combinational), else 000.
REQ-021 UPD: core_instruction=100, core_processor_id=p, core_new_good/bad = pending_good[p]/pending_bad[p]; pending[p] cleared at the clock edge; next EVAL.
REQ-022 EVAL: core_instruction=101, core_processor_id=p; next CAPT.
REQ-023 CAPT: core_instruction=000; core_token_startstop 10 or 01 pushes {p, start}; 00 or 11 pushes nothing.
REQ-024 CAPT with push needed and FIFO full: hold CAPT (core output stable, instruction 000) until space; no event lost or duplicated.
REQ-025 CAPT done: p<NUM_PROCESSORS-1 -> p+1, UPD; else IDLE.
REQ-026 core_clock_slow=1 in UPD, EVAL, CAPT; 0 otherwise; one decrement per processor per sweep.
REQ-027 busy=1 in INIT, UPD, EVAL, CAPT.
REQ-028 Pending accumulators: per-processor signed NEW_TOKENS_BITS good/bad; inj_valid adds inj_good/inj_bad to entry inj_id, saturating to [-2^(NEW_TOKENS_BITS-1), 2^(NEW_TOKENS_BITS-1)-1]; inj_id>=NUM_PROCESSORS ignored.
REQ-029 Injection to the entry being cleared in UPD that cycle: entry becomes the injected value alone (counts toward next sweep).
REQ-030 tick while not in IDLE: tick_pending set; tick while tick_pending already 1: tick_overrun set, cleared only by reset.
REQ-031 FIFO: FIFO_DEPTH entries, first-in-first-out; evt_valid = not empty; pop on evt_valid&evt_ready; simultaneous push and pop when full is not possible (push stalls per REQ-024); simultaneous push and pop otherwise keeps count.

Reset
REQ-032 reset (any state, mid-sweep included): state INIT, p=0, FIFO empty, pending accumulators 0, tick_pending 0, tick_overrun 0, evt_valid 0, prog_ready 0, core_reset 1, core_instruction 000, core_clock_slow 0.
REQ-033 Any in-flight sweep abandoned; tick or injections during reset ignored.

Verification
REQ-034 Reset deasserted, NUM_PROCESSORS=10 -> core_reset high 10 cycles with ids 0..9, then IDLE, prog_ready=1.
REQ-035 IDLE, prog_sel=2, prog_id=3, prog_data=5 -> same cycle core_instruction=010, id 3, data 5; tick simultaneous -> prog_ready=0, sweep starts.
REQ-036 Inject good +5 twice to processor 2, then tick -> UPD for p=2 drives core_new_good=7 (saturated), core_new_bad=0; next sweep drives 0.
REQ-037 Core returns 10 for p=1, 01 for p=4, evt_ready=1 -> events (1,start), (4,stop) in order; sweep lasts 30 cycles.
REQ-038 evt_ready=0, 5 processors return 10 -> 4 queued, sweep holds in CAPT at 5th; raising evt_ready resumes, 5 events delivered in id order.
REQ-039 Two ticks during a sweep -> tick_overrun=1, exactly one further sweep runs; reset mid-sweep -> INIT, FIFO empty.
